// File: rtl/dino_pkg.sv
// ============================================================================
// Module      : dino_pkg
// Description : Shared types and geometry constants for the dino game blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dino_pkg;

  localparam int COORD_W = 8;

  // Player hitbox placement is shared with the renderer.
  localparam logic [COORD_W-1:0] DEFAULT_PLAYER_X = 8'd16;
  localparam logic [COORD_W-1:0] DEFAULT_PLAYER_W = 8'd8;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    CACTUS    = 2'd1,
    BIRD_LOW  = 2'd2,
    BIRD_HIGH = 2'd3
  } obstacle_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/player_hit_test.sv
// ============================================================================
// Module      : player_hit_test
// Description : Combinational hit test of one obstacle slot vs. the player box.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_hit_test
  import dino_pkg::*;
#(
  parameter logic [COORD_W-1:0] PLAYER_X       = DEFAULT_PLAYER_X,
  parameter logic [COORD_W-1:0] PLAYER_W       = DEFAULT_PLAYER_W,
  parameter logic [COORD_W-1:0] OBST_W         = 8'd8,
  parameter logic [COORD_W-1:0] CACTUS_H       = 8'd12,
  parameter logic [COORD_W-1:0] BIRD_LOW_CLEAR = 8'd20,
  parameter logic [COORD_W-1:0] BIRD_HIGH_MIN  = 8'd24
) (
  input  logic [COORD_W-1:0] obstacle_x,
  input  logic [1:0]         obstacle_type,
  input  logic [COORD_W-1:0] player_position,
  input  logic               ducking,
  output logic               hit
);

  logic [COORD_W:0] x_ext;
  logic             overlap;
  logic             vertical;

  always_comb begin
    // One extra bit keeps the edge sums from wrapping near the screen edge.
    x_ext   = {1'b0, obstacle_x};
    overlap = (x_ext < ({1'b0, PLAYER_X} + {1'b0, PLAYER_W})) &&
              ((x_ext + {1'b0, OBST_W}) > {1'b0, PLAYER_X});

    vertical = 1'b0;
    case (obstacle_type_e'(obstacle_type))
      CACTUS:    vertical = (player_position < CACTUS_H);
      BIRD_LOW:  vertical = !ducking && (player_position < BIRD_LOW_CLEAR);
      BIRD_HIGH: vertical = (player_position >= BIRD_HIGH_MIN);
      default:   vertical = 1'b0;
    endcase

    hit = overlap && vertical;
  end

endmodule

`default_nettype wire

// File: rtl/player_collision.sv
// ============================================================================
// Module      : player_collision
// Description : Sequential per-slot collision scan producing a registered crash.
//               PLAYER_COLLISION_STICKY_EN makes crash sticky until
//               game_start_pulse or reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_collision
  import dino_pkg::*;
#(
  parameter int                 NUM_OBSTACLES  = 4,
  parameter logic [COORD_W-1:0] PLAYER_X       = DEFAULT_PLAYER_X,
  parameter logic [COORD_W-1:0] PLAYER_W       = DEFAULT_PLAYER_W,
  parameter logic [COORD_W-1:0] OBST_W         = 8'd8,
  parameter logic [COORD_W-1:0] CACTUS_H       = 8'd12,
  parameter logic [COORD_W-1:0] BIRD_LOW_CLEAR = 8'd20,
  parameter logic [COORD_W-1:0] BIRD_HIGH_MIN  = 8'd24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   game_tick,
  input  logic [COORD_W-1:0]           player_position,
  input  logic                         ducking,
  input  logic                         game_start_pulse,
  input  logic [8*NUM_OBSTACLES-1:0]   obstacle_x,
  input  logic [2*NUM_OBSTACLES-1:0]   obstacle_type,
  output logic                         crash,
  output logic [2:0]                   hit_index,
  output logic                         scan_busy
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_OBSTACLES - 1);

  scan_state_e         state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic                hit_acc_q, hit_acc_d;
  logic [2:0]          hit_first_q, hit_first_d;
  logic                crash_q, crash_d;
  logic [2:0]          hit_index_q, hit_index_d;

  logic [COORD_W-1:0]  sel_x;
  logic [1:0]          sel_type;
  logic                hit_now;
  logic                commit;
  logic                scan_hit;
  logic [2:0]          scan_index;

  always_comb begin
    sel_x    = '0;
    sel_type = '0;
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      if (idx_q == 3'(i)) begin
        sel_x    = obstacle_x[8*i +: 8];
        sel_type = obstacle_type[2*i +: 2];
      end
    end
  end

  player_hit_test #(
    .PLAYER_X       (PLAYER_X),
    .PLAYER_W       (PLAYER_W),
    .OBST_W         (OBST_W),
    .CACTUS_H       (CACTUS_H),
    .BIRD_LOW_CLEAR (BIRD_LOW_CLEAR),
    .BIRD_HIGH_MIN  (BIRD_HIGH_MIN)
  ) u_hit_test (
    .obstacle_x      (sel_x),
    .obstacle_type   (sel_type),
    .player_position (player_position),
    .ducking         (ducking),
    .hit             (hit_now)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hit_acc_d   = hit_acc_q;
    hit_first_d = hit_first_q;
    hit_index_d = hit_index_q;
    crash_d     = crash_q;
    commit      = 1'b0;

    scan_hit   = hit_acc_q | hit_now;
    scan_index = hit_acc_q ? hit_first_q : (hit_now ? idx_q : 3'd0);

    case (state_q)
      IDLE: begin
        if (game_tick[1]) begin
          state_d     = SCAN;
          idx_d       = 3'd0;
          hit_acc_d   = 1'b0;
          hit_first_d = 3'd0;
        end
      end
      SCAN: begin
        // A fresh tick restarts the scan and discards the partial result.
        if (game_tick[1]) begin
          idx_d       = 3'd0;
          hit_acc_d   = 1'b0;
          hit_first_d = 3'd0;
        end else begin
          if (hit_now && !hit_acc_q) begin
            hit_first_d = idx_q;
          end
          hit_acc_d = scan_hit;
          if (idx_q == LAST_IDX) begin
            commit  = 1'b1;
            state_d = IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      hit_index_d = scan_index;
    end

`ifdef PLAYER_COLLISION_STICKY_EN
    if (game_start_pulse) begin
      crash_d = 1'b0;
    end else if (commit && scan_hit) begin
      crash_d = 1'b1;
    end
`else
    if (commit) begin
      crash_d = scan_hit;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      hit_acc_q   <= 1'b0;
      hit_first_q <= 3'd0;
      crash_q     <= 1'b0;
      hit_index_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_acc_q   <= hit_acc_d;
      hit_first_q <= hit_first_d;
      crash_q     <= crash_d;
      hit_index_q <= hit_index_d;
    end
  end

  assign crash     = crash_q;
  assign hit_index = hit_index_q;
  assign scan_busy = (state_q == SCAN);

  logic unused_inputs;
`ifdef PLAYER_COLLISION_STICKY_EN
  assign unused_inputs = game_tick[0];
`else
  assign unused_inputs = game_tick[0] ^ game_start_pulse;
`endif

endmodule

`default_nettype wire
